timing_detector: RTL and testbench

TIMING_DETECTOR -- requirements
Module: timing_detector

---
 rtl/timing_detector.sv | 240 ++++++++++++++++++++++++
 tb/tb_timing_detector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/timing_detector.sv
// Video timing detector.
// Measures horizontal and vertical timing of a {vsync, hsync, den} stream, publishes one
// measurement per frame and reports lock once consecutive frames agree.
//
// Ports:
//   clk, rst         - single clock, synchronous active-high reset
//   sync_in[2:0]     - {vsync, hsync, den}, active high
//   h_total, h_size  - clocks per line, den-high clocks of the first den pulse
//   h_sync, h_start  - hsync-high clocks, clocks from hsync rise to den rise
//   v_total, v_size  - lines per frame, lines containing den
//   v_sync, v_start  - lines with vsync high, index of the first den line
//   meas_valid       - one-cycle pulse when a new measurement is published
//   locked           - timing stable
//   err_cnt          - lock-loss count, only when TIMING_DET_ERRCNT_EN is defined
module timing_detector #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sync_in,
  output logic [11:0] h_total,
  output logic [11:0] h_size,
  output logic [10:0] h_sync,
  output logic [10:0] h_start,
  output logic [10:0] v_total,
  output logic [10:0] v_size,
  output logic [9:0]  v_sync,
  output logic [9:0]  v_start,
  output logic        meas_valid,
`ifdef TIMING_DET_ERRCNT_EN
  output logic [15:0] err_cnt,
`endif
  output logic        locked
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned MW = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam logic [TW-1:0] ToMax = TW'(TIMEOUT);
  localparam logic [MW:0]   SfMax = (MW + 1)'(STABLE_FRAMES);

  typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} state_e;

  typedef struct packed {
    logic [11:0] htot;
    logic [11:0] hsize;
    logic [10:0] hsync;
    logic [10:0] hstart;
    logic [10:0] vtot;
    logic [10:0] vsize;
    logic [9:0]  vsync;
    logic [9:0]  vstart;
  } meas_t;

  function automatic logic [11:0] inc12(logic [11:0] x);
    return (&x) ? x : x + 12'd1;
  endfunction
  function automatic logic [10:0] inc11(logic [10:0] x);
    return (&x) ? x : x + 11'd1;
  endfunction
  function automatic logic [9:0] inc10(logic [9:0] x);
    return (&x) ? x : x + 10'd1;
  endfunction
  function automatic logic [10:0] sat11(logic [11:0] x);
    return x[11] ? 11'h7ff : x[10:0];
  endfunction
  function automatic logic [9:0] sat10(logic [10:0] x);
    return x[10] ? 10'h3ff : x[9:0];
  endfunction

  logic [2:0]    s1_q, s2_q;
  logic [11:0]   h_cnt_q, h_cnt_d;
  logic [10:0]   v_cnt_q, v_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  meas_t         acc_q, acc_d;     // running measurement of the current frame
  meas_t         cur;              // current frame closed at this cycle
  meas_t         pub_q, pub_d;
  logic          den_seen_q, den_seen_d, den_done_q, den_done_d, line_den_q, line_den_d;
  state_e        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [MW:0]   match_inc;
  logic          pub, same, timeout;
  logic          hr, hf, vr, dr, df;

  assign hr = s1_q[1] & ~s2_q[1];
  assign hf = ~s1_q[1] & s2_q[1];
  assign vr = s1_q[2] & ~s2_q[2];
  assign dr = s1_q[0] & ~s2_q[0];
  assign df = ~s1_q[0] & s2_q[0];

  // Measurement accumulators.
  always_comb begin
    h_cnt_d    = hr ? 12'd1 : inc12(h_cnt_q);
    to_cnt_d   = hr ? '0 : ((to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + 1'b1);
    v_cnt_d    = v_cnt_q;
    acc_d      = acc_q;
    den_seen_d = den_seen_q;
    den_done_d = den_done_q;
    line_den_d = line_den_q;

    if (hr) begin
      acc_d.htot = h_cnt_q;
      if (line_den_q) acc_d.vsize = inc11(acc_q.vsize);
      if (s1_q[2])    acc_d.vsync = inc10(acc_q.vsync);
      v_cnt_d    = inc11(v_cnt_q);
      line_den_d = 1'b0;
    end
    if (hf) acc_d.hsync = sat11(h_cnt_q);
    if (dr) begin
      line_den_d = 1'b1;
      if (!den_seen_q) begin
        den_seen_d    = 1'b1;
        acc_d.hstart = sat11(h_cnt_q);
        acc_d.vstart = sat10(v_cnt_q);
      end
    end
    if (df && den_seen_q && !den_done_q) begin
      den_done_d   = 1'b1;
      acc_d.hsize = h_cnt_q - {1'b0, acc_q.hstart};
    end

    // The closing line belongs to the old frame; the new frame starts afterwards.
    cur      = acc_q;
    cur.vtot = inc11(v_cnt_q);
    if (hr) begin
      cur.htot = h_cnt_q;
      if (line_den_q) cur.vsize = inc11(acc_q.vsize);
    end

    if (vr) begin
      v_cnt_d      = '0;
      acc_d.vsync  = 10'd1;
      acc_d.vsize  = '0;
      acc_d.hstart = '0;
      acc_d.hsize  = '0;
      acc_d.vstart = '0;
      den_seen_d   = 1'b0;
      den_done_d   = 1'b0;
    end
  end

  // Frame-level state machine.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    pub       = 1'b0;
    same      = (cur == pub_q);
    timeout   = (to_cnt_q == ToMax) && !hr;
    match_inc = {1'b0, match_q} + 1'b1;

    if (timeout && state_q != StSearch) begin
      state_d = StSearch;
    end else if (vr) begin
      unique case (state_q)
        StSearch:  state_d = StMeasure;
        StMeasure: begin
          pub     = 1'b1;
          state_d = StCheck;
          match_d = '0;
        end
        StCheck: begin
          pub = 1'b1;
          if (!same) begin
            match_d = '0;
          end else begin
            match_d = match_inc[MW-1:0];
            if (match_inc >= SfMax) state_d = StLocked;
          end
        end
        StLocked: begin
          pub = 1'b1;
          if (!same) begin
            state_d = StCheck;
            match_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
    pub_d = pub ? cur : pub_q;
  end

`ifdef TIMING_DET_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic        loss;
  assign loss    = (state_q == StLocked) && (state_d != StLocked);
  assign err_d   = (loss && err_q != 16'hffff) ? err_q + 16'd1 : err_q;
  assign err_cnt = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      to_cnt_q   <= '0;
      acc_q      <= '0;
      pub_q      <= '0;
      den_seen_q <= 1'b0;
      den_done_q <= 1'b0;
      line_den_q <= 1'b0;
      state_q    <= StSearch;
      match_q    <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
`ifdef TIMING_DET_ERRCNT_EN
      err_q      <= '0;
`endif
    end else begin
      s1_q       <= sync_in;
      s2_q       <= s1_q;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      to_cnt_q   <= to_cnt_d;
      acc_q      <= acc_d;
      pub_q      <= pub_d;
      den_seen_q <= den_seen_d;
      den_done_q <= den_done_d;
      line_den_q <= line_den_d;
      state_q    <= state_d;
      match_q    <= match_d;
      meas_valid <= pub;
      locked     <= (state_d == StLocked);
`ifdef TIMING_DET_ERRCNT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign h_total = pub_q.htot;
  assign h_size  = pub_q.hsize;
  assign h_sync  = pub_q.hsync;
  assign h_start = pub_q.hstart;
  assign v_total = pub_q.vtot;
  assign v_size  = pub_q.vsize;
  assign v_sync  = pub_q.vsync;
  assign v_start = pub_q.vstart;

endmodule

// File: tb/tb_timing_detector.sv
// Directed bench for timing_detector: nominal lock, mode change, timeout, no-den frames,
// mid-frame reset and (with TIMING_DET_ERRCNT_EN) the lock-loss counter.
module tb_timing_detector;

  localparam int HSYN = 2, HST = 4, HSZ = 12, VTOT = 10, VSYN = 1, VST = 3, VSZ = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sync_in = '0;
  logic [11:0] h_total, h_size;
  logic [10:0] h_sync, h_start, v_total, v_size;
  logic [9:0]  v_sync, v_start;
  logic        meas_valid, locked;
`ifdef TIMING_DET_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  timing_detector #(.STABLE_FRAMES(2), .TIMEOUT(4095)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (sync_in),
    .h_total   (h_total),
    .h_size    (h_size),
    .h_sync    (h_sync),
    .h_start   (h_start),
    .v_total   (v_total),
    .v_size    (v_size),
    .v_sync    (v_sync),
    .v_start   (v_start),
    .meas_valid(meas_valid),
`ifdef TIMING_DET_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vr_n = 0;
  int vr_cyc [0:63];
  int mv_n = 0, last_mv_cyc = 0;
  int lock_rise_cyc = -1, lock_rise_vrn = -1, lock_fall_cyc = -1;
  logic lock_prev = 1'b0;
  logic prev_vs = 1'b0;
  int base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      mv_n++;
      last_mv_cyc = cyc;
    end
    if (locked && !lock_prev) begin
      lock_rise_cyc = cyc;
      lock_rise_vrn = vr_n;
    end
    if (!locked && lock_prev) lock_fall_cyc = cyc;
    lock_prev = locked;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string pfx, input int ht, input int hz, input int hs,
                            input int hb, input int vt, input int vz, input int vs,
                            input int vb);
    check_eq({pfx, ".h_total"}, 32'(h_total), ht);
    check_eq({pfx, ".h_size"},  32'(h_size),  hz);
    check_eq({pfx, ".h_sync"},  32'(h_sync),  hs);
    check_eq({pfx, ".h_start"}, 32'(h_start), hb);
    check_eq({pfx, ".v_total"}, 32'(v_total), vt);
    check_eq({pfx, ".v_size"},  32'(v_size),  vz);
    check_eq({pfx, ".v_sync"},  32'(v_sync),  vs);
    check_eq({pfx, ".v_start"}, 32'(v_start), vb);
  endtask

  task automatic drive_px(input logic [2:0] v);
    @(negedge clk);
    sync_in = v;
    if (v[2] && !prev_vs) begin
      vr_n++;
      if (vr_n < 64) vr_cyc[vr_n] = cyc;
    end
    prev_vs = v[2];
  endtask

  // Let the monitor see the last driven cycle before checks read its counters.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int htot, input bit den_en, input int rst_line);
    logic [2:0] v;
    for (int l = 0; l < VTOT; l++) begin
      for (int p = 0; p < htot; p++) begin
        v[2] = (l < VSYN);
        v[1] = (p < HSYN);
        v[0] = den_en && l >= VST && l < VST + VSZ && p >= HST && p < HST + HSZ;
        drive_px(v);
        rst = (l == rst_line) && (p == 0);
      end
    end
    settle();
  endtask

  task automatic drive_frames(input int n, input int htot, input bit den_en);
    for (int i = 0; i < n; i++) drive_frame(htot, den_en, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("reset.locked", 32'(locked), 0);
    check_eq("reset.meas_valid", 32'(meas_valid), 0);

    // Nominal timing: locks on the 4th vsync rise.
    drive_frames(3, 20, 1'b1);
    check_eq("nom.unlocked_after3", 32'(locked), 0);
    check_eq("nom.meas_count3", 32'(mv_n), 2);
    drive_frames(1, 20, 1'b1);
    check_eq("nom.lock_vr", 32'(lock_rise_vrn), 4);
    check_eq("nom.lock_latency", 32'(lock_rise_cyc - vr_cyc[4]), 2);
    check_eq("nom.mv_latency", 32'(last_mv_cyc - vr_cyc[4]), 2);
    check_eq("nom.meas_count4", 32'(mv_n), 3);
    check_outs("nom", 20, 12, 2, 4, 10, 5, 1, 3);

    // Mode change to h_total=24 while locked.
    drive_frames(1, 24, 1'b1);
    check_eq("mode.still_locked", 32'(locked), 1);
    drive_frames(3, 24, 1'b1);
    check_eq("mode.fall_latency", 32'(lock_fall_cyc - vr_cyc[6]), 2);
    check_eq("mode.relock_vr", 32'(lock_rise_vrn), 8);
    check_eq("mode.locked", 32'(locked), 1);
    check_outs("mode", 24, 12, 2, 4, 10, 5, 1, 3);

    // Back to nominal and relock.
    drive_frames(4, 20, 1'b1);
    check_eq("back.locked", 32'(locked), 1);
    check_eq("back.relock_vr", 32'(lock_rise_vrn), 12);
    check_eq("back.h_total", 32'(h_total), 20);

    // Timeout: no hsync for more than TIMEOUT clocks.
    repeat (4100) drive_px(3'b000);
    settle();
    check_eq("timeout.locked", 32'(locked), 0);
    check_outs("timeout", 20, 12, 2, 4, 10, 5, 1, 3);
`ifdef TIMING_DET_ERRCNT_EN
    check_eq("errcnt.three", 32'(err_cnt), 3);
`endif
    // From SEARCH the first publish needs two vsync rises.
    base = mv_n;
    drive_frames(1, 20, 1'b1);
    check_eq("search.no_publish", 32'(mv_n), base);
    drive_frames(1, 20, 1'b1);
    check_eq("search.one_publish", 32'(mv_n), base + 1);

    // Frames without den.
    drive_frames(2, 20, 1'b0);
    check_eq("noden.meas_count", 32'(mv_n), base + 3);
    check_outs("noden", 20, 0, 2, 0, 10, 0, 1, 0);

    // Reset at line 5 of a frame.
    drive_frame(20, 1'b1, 5);
    check_outs("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("midrst.locked", 32'(locked), 0);
`ifdef TIMING_DET_ERRCNT_EN
    check_eq("midrst.err_cnt", 32'(err_cnt), 0);
`endif
    base = mv_n;
    drive_frames(1, 20, 1'b1);
    check_eq("midrst.no_publish", 32'(mv_n), base);
    check_eq("midrst.h_total_zero", 32'(h_total), 0);
    drive_frames(1, 20, 1'b1);
    check_eq("midrst.first_publish", 32'(mv_n), base + 1);
    check_outs("midrst.pub", 20, 12, 2, 4, 10, 5, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
